// File: rtl/bdd_mem_pkg.sv
// Shared definitions for the BDD node/unique-table storage banks: clear-FSM
// state type, byte width and the byte-enable merge helper.
package bdd_mem_pkg;

    localparam int unsigned BYTE_W     = 8;
    // Widest word the merge helper handles; callers zero-extend and truncate.
    localparam int unsigned MAX_DATA_W = 256;
    localparam int unsigned MAX_BE_W   = MAX_DATA_W / BYTE_W;

    typedef enum logic [0:0] {
        StIdle,
        StClear
    } clear_state_e;

    // Bytes with be=1 come from new_word, the rest from old_word.
    function automatic logic [MAX_DATA_W-1:0] merge_be(
        input logic [MAX_DATA_W-1:0] old_word,
        input logic [MAX_DATA_W-1:0] new_word,
        input logic [MAX_BE_W-1:0]   be
    );
        logic [MAX_DATA_W-1:0] res;
        res = old_word;
        for (int k = 0; k < int'(MAX_BE_W); k++) begin
            if (be[k]) begin
                res[k*BYTE_W +: BYTE_W] = new_word[k*BYTE_W +: BYTE_W];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/sram_dp_bank_if.sv
// Bus bundle of the dual-port SRAM bank: clear control, write port, read request
// port and read response port. master = client side, slave = the bank.
interface sram_dp_bank_if
    import bdd_mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 32
);
    localparam int unsigned BE_WIDTH = DATA_WIDTH / BYTE_W;

    logic                  i_clear;
    logic                  o_busy;
    logic                  i_wr_valid;
    logic                  o_wr_ready;
    logic [ADDR_WIDTH-1:0] i_wr_addr;
    logic [DATA_WIDTH-1:0] i_wr_data;
    logic [BE_WIDTH-1:0]   i_wr_be;
    logic                  i_rd_valid;
    logic                  o_rd_ready;
    logic [ADDR_WIDTH-1:0] i_rd_addr;
    logic                  o_rd_valid;
    logic                  i_rd_rdy;
    logic [DATA_WIDTH-1:0] o_rd_data;

    modport master (
        output i_clear, i_wr_valid, i_wr_addr, i_wr_data, i_wr_be,
               i_rd_valid, i_rd_addr, i_rd_rdy,
        input  o_busy, o_wr_ready, o_rd_ready, o_rd_valid, o_rd_data
    );

    modport slave (
        input  i_clear, i_wr_valid, i_wr_addr, i_wr_data, i_wr_be,
               i_rd_valid, i_rd_addr, i_rd_rdy,
        output o_busy, o_wr_ready, o_rd_ready, o_rd_valid, o_rd_data
    );

endinterface

// File: rtl/sram_rd_pipe.sv
// Read response pipeline: STAGES registered stages with valid/ready flow control.
// A stage advances when the stage after it is empty or being drained; data of an
// emptied stage is kept so the output holds its last value.
module sram_rd_pipe #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned STAGES     = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_busy,
    input  logic                  i_in_valid,
    output logic                  o_in_ready,
    input  logic [DATA_WIDTH-1:0] i_in_data,
    output logic                  o_out_valid,
    input  logic                  i_out_rdy,
    output logic [DATA_WIDTH-1:0] o_out_data
);

    logic [STAGES-1:0]     valid_q, valid_d, can_load;
    logic [DATA_WIDTH-1:0] data_q [STAGES];
    logic [DATA_WIDTH-1:0] data_d [STAGES];
    logic                  in_fire;

    // A stage can load when it is empty or its occupant moves downstream this cycle.
    always_comb begin
        logic chain;
        chain    = i_out_rdy;
        can_load = '0;
        for (int k = int'(STAGES) - 1; k >= 0; k--) begin
            chain       = !valid_q[k] || chain;
            can_load[k] = chain;
        end
    end

    assign o_in_ready = !i_busy && can_load[0];
    assign in_fire    = i_in_valid && o_in_ready;

    // Next-state of each stage: load from upstream when allowed, else hold.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (can_load[0]) begin
            valid_d[0] = in_fire;
            if (in_fire) begin
                data_d[0] = i_in_data;
            end
        end
        for (int k = 1; k < int'(STAGES); k++) begin
            if (can_load[k]) begin
                valid_d[k] = valid_q[k-1];
                if (valid_q[k-1]) begin
                    data_d[k] = data_q[k-1];
                end
            end
        end
    end

    // Stage registers; reset clears valids and data.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            valid_q <= '0;
            data_q  <= '{default: '0};
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign o_out_valid = valid_q[STAGES-1];
    assign o_out_data  = data_q[STAGES-1];

endmodule

// File: rtl/sram_dp_bank.sv
// Simple-dual-port SRAM bank with handshaked write/read ports, byte enables,
// write-first collision behaviour and a zero-fill clear sequencer.
// Define SRAM_OUTREG_EN to add a second read response register (latency 2).
module sram_dp_bank
    import bdd_mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 32
) (
    input logic           i_clk,
    input logic           i_rst,
    sram_dp_bank_if.slave bus
);

`ifdef SRAM_OUTREG_EN
    localparam int unsigned RdStages = 2;
`else
    localparam int unsigned RdStages = 1;
`endif
    localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   DepthW   = (ADDR_WIDTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    clear_state_e          state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  busy, wr_fire, wr_in_range, rd_in_range;
    logic [DATA_WIDTH-1:0] wr_old, wr_merged, rd_word;

    assign busy        = (state_q == StClear);
    assign wr_fire     = bus.i_wr_valid && !busy;
    assign wr_in_range = ({1'b0, bus.i_wr_addr} < DepthW);
    assign rd_in_range = ({1'b0, bus.i_rd_addr} < DepthW);
    assign wr_old      = wr_in_range ? mem_q[bus.i_wr_addr] : '0;
    assign wr_merged   = DATA_WIDTH'(merge_be(MAX_DATA_W'(wr_old), MAX_DATA_W'(bus.i_wr_data),
                                              MAX_BE_W'(bus.i_wr_be)));

    // Write-first: a same-cycle write to the read address is visible in the response.
    always_comb begin
        rd_word = '0;
        if (rd_in_range) begin
            rd_word = (wr_fire && (bus.i_wr_addr == bus.i_rd_addr)) ? wr_merged
                                                                     : mem_q[bus.i_rd_addr];
        end
    end

    // Clear sequencer next-state: sweep addresses 0..DEPTH-1, one per cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (bus.i_clear) begin
                    state_d = StClear;
                    cnt_d   = '0;
                end
            end
            StClear: begin
                if (cnt_q == LastAddr) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase
    end

    // Clear sequencer state register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Array update; contents survive reset, and a reset edge suppresses any write.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            if (busy) begin
                mem_q[cnt_q] <= '0;
            end else if (wr_fire && wr_in_range) begin
                mem_q[bus.i_wr_addr] <= wr_merged;
            end
        end
    end

    sram_rd_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .STAGES     (RdStages)
    ) u_rd_pipe (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_busy      (busy),
        .i_in_valid  (bus.i_rd_valid),
        .o_in_ready  (bus.o_rd_ready),
        .i_in_data   (rd_word),
        .o_out_valid (bus.o_rd_valid),
        .i_out_rdy   (bus.i_rd_rdy),
        .o_out_data  (bus.o_rd_data)
    );

    assign bus.o_busy     = busy;
    assign bus.o_wr_ready = !busy;

endmodule

// File: tb/tb_sram_dp_bank.sv
// Bench for sram_dp_bank: directed scenarios followed by randomized traffic checked
// against a queue-based model of the response path and an array model of the storage.
module tb_sram_dp_bank;

    localparam int unsigned AW    = 5;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 32;
`ifdef SRAM_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    typedef struct packed {
        logic [31:0] data;
        logic [7:0]  age;
    } resp_t;

    logic        clk;
    logic        rst;
    int          checks;
    int          errors;
    int          n_busy;
    logic [31:0] last_rd;
    logic [31:0] bp_exp [2];
    logic [31:0] ref_mem [DEPTH];
    resp_t       q [$];
    logic        wv, rv, rr, vis, exp_rr;
    logic [4:0]  wa, ra;
    logic [31:0] wd, rdat;
    logic [3:0]  wbe;

    sram_dp_bank_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    sram_dp_bank #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] apply_be(input logic [31:0] old_w, input logic [31:0] new_w,
                                             input logic [3:0] be);
        logic [31:0] mask;
        mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        return (old_w & ~mask) | (new_w & mask);
    endfunction

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_word(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.i_clear    = 1'b0;
        bus.i_wr_valid = 1'b0;
        bus.i_wr_addr  = '0;
        bus.i_wr_data  = '0;
        bus.i_wr_be    = '0;
        bus.i_rd_valid = 1'b0;
        bus.i_rd_addr  = '0;
        bus.i_rd_rdy   = 1'b0;
    endtask

    task automatic do_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
        bus.i_wr_valid = 1'b1;
        bus.i_wr_addr  = a;
        bus.i_wr_data  = d;
        bus.i_wr_be    = be;
        #1;
        check_bit("wr_ready", bus.o_wr_ready, 1'b1);
        tick();
        bus.i_wr_valid = 1'b0;
    endtask

    // Response must appear exactly LAT edges after acceptance, then drain once.
    task automatic await_resp(input string tag, input logic [31:0] exp);
        for (int k = 1; k < LAT; k++) begin
            check_bit({tag, "_early_valid"}, bus.o_rd_valid, 1'b0);
            tick();
        end
        check_bit({tag, "_valid"}, bus.o_rd_valid, 1'b1);
        check_word({tag, "_data"}, bus.o_rd_data, exp);
        last_rd = exp;
        bus.i_rd_rdy = 1'b1;
        tick();
        check_bit({tag, "_drained"}, bus.o_rd_valid, 1'b0);
    endtask

    task automatic do_read(input string tag, input logic [4:0] a, input logic [31:0] exp);
        bus.i_rd_valid = 1'b1;
        bus.i_rd_addr  = a;
        bus.i_rd_rdy   = 1'b1;
        #1;
        check_bit({tag, "_rd_ready"}, bus.o_rd_ready, 1'b1);
        tick();
        bus.i_rd_valid = 1'b0;
        await_resp(tag, exp);
    endtask

    task automatic do_wr_rd(input string tag, input logic [4:0] a, input logic [31:0] d,
                            input logic [3:0] be, input logic [31:0] exp);
        bus.i_wr_valid = 1'b1;
        bus.i_wr_addr  = a;
        bus.i_wr_data  = d;
        bus.i_wr_be    = be;
        bus.i_rd_valid = 1'b1;
        bus.i_rd_addr  = a;
        bus.i_rd_rdy   = 1'b1;
        #1;
        check_bit({tag, "_rd_ready"}, bus.o_rd_ready, 1'b1);
        tick();
        bus.i_wr_valid = 1'b0;
        bus.i_rd_valid = 1'b0;
        await_resp(tag, exp);
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        last_rd = '0;
        drive_idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        check_bit("rst_busy", bus.o_busy, 1'b0);
        check_bit("rst_rd_valid", bus.o_rd_valid, 1'b0);
        check_word("rst_rd_data", bus.o_rd_data, 32'h0);
        check_bit("rst_wr_ready", bus.o_wr_ready, 1'b1);
        check_bit("rst_rd_ready", bus.o_rd_ready, 1'b1);

        // Full write then read back.
        do_write(5'd3, 32'hDEADBEEF, 4'hF);
        do_read("t1", 5'd3, 32'hDEADBEEF);

        // Partial byte-enable write keeps bytes 3 and 1.
        do_write(5'd3, 32'h11223344, 4'b0101);
        do_read("t2", 5'd3, 32'hDE22BE44);

        // Same-cycle write and read of one address returns the new bytes.
        do_write(5'd7, 32'h00000000, 4'hF);
        do_wr_rd("t3_full", 5'd7, 32'hA5A5A5A5, 4'hF, 32'hA5A5A5A5);
        do_wr_rd("t3_part", 5'd7, 32'h12345678, 4'b0011, 32'hA5A55678);
        do_read("t3_after", 5'd7, 32'hA5A55678);

        // Backpressure: fill the response path, hold, then release.
        do_write(5'd5, 32'hCAFEF00D, 4'hF);
        bp_exp[0] = 32'hCAFEF00D;
        bp_exp[1] = 32'hDE22BE44;
        bus.i_rd_rdy = 1'b0;
        for (int n = 0; n < LAT; n++) begin
            bus.i_rd_valid = 1'b1;
            bus.i_rd_addr  = (n == 0) ? 5'd5 : 5'd3;
            #1;
            check_bit("t4_accept_ready", bus.o_rd_ready, 1'b1);
            tick();
        end
        bus.i_rd_addr = 5'd9;
        for (int n = 0; n < 5; n++) begin
            #1;
            check_bit("t4_hold_valid", bus.o_rd_valid, 1'b1);
            check_word("t4_hold_data", bus.o_rd_data, bp_exp[0]);
            check_bit("t4_hold_rd_ready", bus.o_rd_ready, 1'b0);
            tick();
        end
        bus.i_rd_valid = 1'b0;
        bus.i_rd_rdy   = 1'b1;
        for (int n = 0; n < LAT; n++) begin
            check_bit("t4_release_valid", bus.o_rd_valid, 1'b1);
            check_word("t4_release_data", bus.o_rd_data, bp_exp[n]);
            tick();
        end
        check_bit("t4_no_dup_valid", bus.o_rd_valid, 1'b0);
        check_word("t4_held_data", bus.o_rd_data, bp_exp[LAT-1]);
        tick();
        check_bit("t4_no_dup_valid2", bus.o_rd_valid, 1'b0);
        last_rd = bp_exp[LAT-1];

        // Clear: busy for exactly DEPTH cycles, ports blocked, repeated pulse ignored.
        bus.i_clear = 1'b1;
        tick();
        bus.i_clear    = 1'b0;
        bus.i_wr_valid = 1'b1;
        bus.i_wr_addr  = 5'd1;
        bus.i_wr_data  = 32'hFFFFFFFF;
        bus.i_wr_be    = 4'hF;
        bus.i_rd_valid = 1'b1;
        bus.i_rd_addr  = 5'd2;
        bus.i_rd_rdy   = 1'b1;
        check_bit("t5_busy_start", bus.o_busy, 1'b1);
        n_busy = 0;
        while (bus.o_busy === 1'b1 && n_busy < 40) begin
            #1;
            check_bit("t5_wr_ready_low", bus.o_wr_ready, 1'b0);
            check_bit("t5_rd_ready_low", bus.o_rd_ready, 1'b0);
            bus.i_clear = (n_busy == 5);
            n_busy++;
            tick();
        end
        bus.i_clear    = 1'b0;
        bus.i_wr_valid = 1'b0;
        bus.i_rd_valid = 1'b0;
        check_word("t5_busy_cycles", n_busy, 32);
        for (int a = 0; a < int'(DEPTH); a++) begin
            do_read("t5_zero", 5'(a), 32'h0);
        end

        // Reset in the middle of a clear aborts it.
        for (int a = 0; a < 10; a++) begin
            do_write(5'(a), 32'(32'h01010101 * (a + 1)), 4'hF);
        end
        do_write(5'd20, 32'h5A5A0020, 4'hF);
        bus.i_clear = 1'b1;
        tick();
        bus.i_clear = 1'b0;
        for (int n = 0; n < 10; n++) begin
            tick();
        end
        check_bit("t6_busy_before_rst", bus.o_busy, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_bit("t6_busy_after_rst", bus.o_busy, 1'b0);
        check_bit("t6_rd_valid_after_rst", bus.o_rd_valid, 1'b0);
        check_word("t6_rd_data_after_rst", bus.o_rd_data, 32'h0);
        for (int a = 0; a < 10; a++) begin
            do_read("t6_zeroed", 5'(a), 32'h0);
        end
        do_read("t6_kept", 5'd20, 32'h5A5A0020);

        // Randomized traffic against the reference model, starting from a cleared array.
        bus.i_clear = 1'b1;
        tick();
        bus.i_clear = 1'b0;
        n_busy = 0;
        while (bus.o_busy === 1'b1 && n_busy < 40) begin
            n_busy++;
            tick();
        end
        check_bit("rnd_clear_done", bus.o_busy, 1'b0);
        foreach (ref_mem[i]) ref_mem[i] = '0;
        q.delete();
        for (int cyc = 0; cyc < 400; cyc++) begin
            vis = (q.size() > 0) && (int'(q[0].age) >= LAT);
            check_bit("rnd_rd_valid", bus.o_rd_valid, vis);
            check_word("rnd_rd_data", bus.o_rd_data, vis ? q[0].data : last_rd);
            wv  = 1'($urandom_range(0, 1));
            wa  = 5'($urandom_range(0, 31));
            wd  = $urandom;
            wbe = 4'($urandom_range(0, 15));
            rv  = 1'($urandom_range(0, 1));
            ra  = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            rr  = ($urandom_range(0, 3) != 0);
            bus.i_wr_valid = wv;
            bus.i_wr_addr  = wa;
            bus.i_wr_data  = wd;
            bus.i_wr_be    = wbe;
            bus.i_rd_valid = rv;
            bus.i_rd_addr  = ra;
            bus.i_rd_rdy   = rr;
            #1;
            exp_rr = (q.size() < LAT) || rr;
            check_bit("rnd_rd_ready", bus.o_rd_ready, exp_rr);
            check_bit("rnd_wr_ready", bus.o_wr_ready, 1'b1);
            rdat = ref_mem[ra];
            if (wv && wa == ra) begin
                rdat = apply_be(rdat, wd, wbe);
            end
            if (vis && rr) begin
                last_rd = q[0].data;
                void'(q.pop_front());
            end
            foreach (q[i]) begin
                if (q[i].age < 8'd8) q[i].age = q[i].age + 8'd1;
            end
            if (rv && exp_rr) begin
                q.push_back('{data: rdat, age: 8'd1});
            end
            if (wv) begin
                ref_mem[wa] = apply_be(ref_mem[wa], wd, wbe);
            end
            tick();
        end
        drive_idle();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
